mma_wb_ctrl: RTL and testbench

Writeback stage directly downstream of the MMA compute array and upstream of the retire tracker. Captures a result-burst descriptor on calc_start and buffers streamed result words in a small FIFO. Writes each word to memory over a valid/ready request channel, counts write responses, then raises mma_wb_valid (with error status) until mma_wb_ready retires the instruction.

---
 rtl/mma_wb_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mma_wb_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mma_wb_ctrl.sv
// MMA writeback stage: buffers result words, writes them to memory, retires.
// Optional latency counter enabled by defining MMA_WB_PERF_EN.
module mma_wb_ctrl #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int CNT_W      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              calc_start,
   input  logic [ADDR_W-1:0] cfg_base_addr,
   input  logic [CNT_W-1:0]  cfg_num_words,
   input  logic              res_valid,
   output logic              res_ready,
   input  logic [DATA_W-1:0] res_data,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_wdata,
   input  logic              mem_rsp_valid,
   input  logic              mem_rsp_err,
   output logic              mma_wb_valid,
   input  logic              mma_wb_ready,
   output logic              mma_wb_err,
   output logic              busy,
   output logic [31:0]       perf_cycles
);

   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, STREAM, RESP} state_t;

   state_t            state;
   state_t            nxt;
   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  num_q;
   logic [CNT_W-1:0]  acc_q;
   logic [CNT_W-1:0]  iss_q;
   logic [CNT_W-1:0]  rsp_q;
   logic              err_q;
   logic              wb_valid_q;
   logic              wb_valid_d;

   logic [DATA_W-1:0] fifo [FIFO_DEPTH];
   logic [PW-1:0]     wp;
   logic [PW-1:0]     rp;
   logic [PW:0]       cnt;

   logic full;
   logic empty;
   logic push;
   logic pop;
   logic rsp_take;
   logic start;

   assign full  = (cnt == (PW+1)'(FIFO_DEPTH));
   assign empty = (cnt == '0);
   assign start = (state == IDLE) && calc_start;

   // Acceptance depends only on registered state, never on mem_req_ready
   assign res_ready = (state == STREAM) && !full && (acc_q < num_q);
   assign push      = res_valid && res_ready;

   assign mem_req_valid = (state == STREAM) && !empty;
   assign pop           = mem_req_valid && mem_req_ready;
   assign mem_req_wdata = mem_req_valid ? fifo[rp] : '0;
   assign mem_req_addr  = base_q + ADDR_W'(iss_q) * ADDR_W'(DATA_W / 8);

   // Responses with nothing outstanding are strays and are dropped
   assign rsp_take = (state == STREAM) && mem_rsp_valid && (iss_q != rsp_q);

   assign mma_wb_valid = wb_valid_q;
   assign mma_wb_err   = wb_valid_q & err_q;
   assign busy         = (state != IDLE);

   always_comb begin
      nxt        = state;
      wb_valid_d = 1'b0;
      unique case (state)
         IDLE: begin
            if (calc_start)
               nxt = (cfg_num_words == '0) ? RESP : STREAM;
         end
         STREAM: begin
            if (rsp_q + CNT_W'(rsp_take) == num_q) begin
               nxt        = RESP;
               wb_valid_d = 1'b1;
            end
         end
         RESP: begin
            if (wb_valid_q && mma_wb_ready)
               nxt = IDLE;
            else
               wb_valid_d = 1'b1;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wb_valid_q <= 1'b0;
         base_q     <= '0;
         num_q      <= '0;
         acc_q      <= '0;
         iss_q      <= '0;
         rsp_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state      <= nxt;
         wb_valid_q <= wb_valid_d;
         if (start) begin
            base_q <= cfg_base_addr;
            num_q  <= cfg_num_words;
            acc_q  <= '0;
            iss_q  <= '0;
            rsp_q  <= '0;
            err_q  <= 1'b0;
         end else begin
            if (push)
               acc_q <= acc_q + 1'b1;
            if (pop)
               iss_q <= iss_q + 1'b1;
            if (rsp_take) begin
               rsp_q <= rsp_q + 1'b1;
               err_q <= err_q | mem_rsp_err;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push)
            wp <= wp + PW'(1);
         if (pop)
            rp <= rp + PW'(1);
         cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      end
   end

   // Storage needs no reset; the head is masked while the buffer is empty
   always_ff @(posedge clk) begin
      if (push)
         fifo[wp] <= res_data;
   end

`ifdef MMA_WB_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         perf_q <= '0;
      else if (start)
         perf_q <= '0;
      else if (busy && (perf_q != 32'hFFFF_FFFF))
         perf_q <= perf_q + 32'd1;
   end

   assign perf_cycles = perf_q;
`else
   assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_mma_wb_ctrl.sv
// Directed bench for mma_wb_ctrl with a write scoreboard and memory model.
// Expected writes are queued at stimulus time and popped on each request.
module tb_mma_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        calc_start = 1'b0;
   logic [31:0] cfg_base_addr = '0;
   logic [7:0]  cfg_num_words = '0;
   logic        res_valid = 1'b0;
   logic        res_ready;
   logic [31:0] res_data = '0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic        mem_rsp_valid;
   logic        mem_rsp_err = 1'b0;
   logic        rsp_m = 1'b0;
   logic        rsp_x = 1'b0;
   logic        mma_wb_valid;
   logic        mma_wb_ready = 1'b0;
   logic        mma_wb_err;
   logic        busy;
   logic [31:0] perf_cycles;

   int total = 0;
   int bad = 0;
   int acc_n = 0;
   int nwr = 0;
   int wr_idx = 0;
   int err_at = -1;
   logic rsp_pend = 1'b0;
   logic rsp_err_p = 1'b0;

   logic [31:0] res_q [$];
   logic [63:0] sb_q [$];

   assign mem_rsp_valid = rsp_m | rsp_x;

   always #5 clk = ~clk;

   mma_wb_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .calc_start    (calc_start),
      .cfg_base_addr (cfg_base_addr),
      .cfg_num_words (cfg_num_words),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_data      (res_data),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wdata (mem_req_wdata),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_err   (mem_rsp_err),
      .mma_wb_valid  (mma_wb_valid),
      .mma_wb_ready  (mma_wb_ready),
      .mma_wb_err    (mma_wb_err),
      .busy          (busy),
      .perf_cycles   (perf_cycles)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Result source: presents queued words, pops on handshake
   always @(posedge clk) begin
      #1;
      res_valid = (res_q.size() > 0);
      res_data  = (res_q.size() > 0) ? res_q[0] : 32'h0;
   end

   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         void'(res_q.pop_front());
         acc_n++;
      end
   end

   // Write monitor: scoreboard compare and schedule a 1-cycle response
   always @(negedge clk) begin
      if (rst_n && mem_req_valid && mem_req_ready) begin
         total++;
         assert (sb_q.size() != 0) else begin
            bad++;
            $error("FAIL extra_write observed=%0h expected=none", mem_req_addr);
         end
         if (sb_q.size() != 0)
            chk("write", {mem_req_addr, mem_req_wdata}, sb_q.pop_front());
         rsp_pend  = 1'b1;
         rsp_err_p = (wr_idx == err_at);
         wr_idx++;
         nwr++;
      end
   end

   always @(posedge clk) begin
      #1;
      rsp_m       = rsp_pend;
      mem_rsp_err = rsp_pend & rsp_err_p;
      rsp_pend    = 1'b0;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_burst(input logic [31:0] base, input int n,
                             input logic [31:0] seed);
      for (int i = 0; i < n; i++) begin
         logic [31:0] d;
         d = seed + 32'h0101_0101 * i;
         res_q.push_back(d);
         sb_q.push_back({base + 32'(4 * i), d});
      end
   endtask

   task automatic start_op(input logic [31:0] base, input logic [7:0] n);
      tick;
      calc_start    = 1'b1;
      cfg_base_addr = base;
      cfg_num_words = n;
   endtask

   // Cycles from the current cycle until mma_wb_valid; -1 on timeout
   task automatic wait_wb(output int lat);
      lat = 0;
      repeat (300) begin
         @(negedge clk);
         if (mma_wb_valid)
            return;
         tick;
         calc_start = 1'b0;
         lat++;
      end
      lat = -1;
   endtask

   task automatic finish_wb(input string tag);
      tick;
      calc_start   = 1'b0;
      mma_wb_ready = 1'b1;
      tick;
      mma_wb_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_valid_drop"}, mma_wb_valid, 0);
      chk({tag, "_busy_drop"}, busy, 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_res_ready"}, res_ready, 0);
      chk({tag, "_req_valid"}, mem_req_valid, 0);
      chk({tag, "_wb_valid"}, mma_wb_valid, 0);
      chk({tag, "_wb_err"}, mma_wb_err, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_addr"}, mem_req_addr, 0);
      chk({tag, "_wdata"}, mem_req_wdata, 0);
      chk({tag, "_perf"}, perf_cycles, 0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int a0;
      int w0;

      #1 rst_n = 1'b0;
      #2;
      chk_zero("reset");
      repeat (3) @(posedge clk);
      tick;
      rst_n = 1'b1;

      // 1: single word, minimum latency
      push_burst(32'h1000, 1, 32'hDEADBEEF);
      mem_req_ready = 1'b1;
      start_op(32'h1000, 8'd1);
      wait_wb(lat);
      chk("t1_latency", lat, 4);
      chk("t1_err", mma_wb_err, 0);
      chk("t1_sb_empty", sb_q.size(), 0);
`ifdef MMA_WB_PERF_EN
      chk("t1_perf", perf_cycles, 3);
`else
      chk("t1_perf", perf_cycles, 0);
`endif
      finish_wb("t1");

      // 2: backpressure fills the buffer, then drains in order
      push_burst(32'h2000, 8, 32'h1000_0001);
      mem_req_ready = 1'b0;
      a0 = acc_n;
      w0 = nwr;
      start_op(32'h2000, 8'd8);
      repeat (20) begin
         tick;
         calc_start = 1'b0;
      end
      @(negedge clk);
      chk("t2_acc_full", acc_n - a0, 4);
      chk("t2_res_ready", res_ready, 0);
      chk("t2_no_write", nwr - w0, 0);
      tick;
      mem_req_ready = 1'b1;
      wait_wb(lat);
      chk("t2_timeout", lat >= 0, 1);
      chk("t2_acc", acc_n - a0, 8);
      chk("t2_writes", nwr - w0, 8);
      chk("t2_sb_empty", sb_q.size(), 0);
      chk("t2_err", mma_wb_err, 0);
      finish_wb("t2");

      // 3: empty burst
      w0 = nwr;
      start_op(32'h4000, 8'd0);
      wait_wb(lat);
      chk("t3_latency", lat, 2);
      chk("t3_err", mma_wb_err, 0);
      chk("t3_writes", nwr - w0, 0);
      finish_wb("t3");

      // 4: error on third response is sticky, cleared by next op
      err_at = 2;
      wr_idx = 0;
      push_burst(32'h6000, 4, 32'hA5A5_0000);
      start_op(32'h6000, 8'd4);
      wait_wb(lat);
      chk("t4_timeout", lat >= 0, 1);
      chk("t4_err", mma_wb_err, 1);
      chk("t4_sb_empty", sb_q.size(), 0);
      finish_wb("t4");
      chk("t4_err_drop", mma_wb_err, 0);
      err_at = -1;
      push_burst(32'h6100, 1, 32'h5A5A_0000);
      start_op(32'h6100, 8'd1);
      wait_wb(lat);
      chk("t4_next_err", mma_wb_err, 0);
      finish_wb("t4n");

      // 5: retire backpressure, calc_start ignored while busy
      w0 = nwr;
      push_burst(32'h7000, 1, 32'h7777_0000);
      start_op(32'h7000, 8'd1);
      wait_wb(lat);
      chk("t5_latency", lat, 4);
      for (int i = 0; i < 10; i++) begin
         tick;
         calc_start    = (i == 3);
         cfg_num_words = 8'd0;
         @(negedge clk);
         chk("t5_hold", mma_wb_valid, 1);
      end
      tick;
      calc_start = 1'b0;
      finish_wb("t5");
      tick;
      tick;
      @(negedge clk);
      chk("t5_idle", busy, 0);
      chk("t5_writes", nwr - w0, 1);

      // 6: reset with two words buffered, then a clean burst
      mem_req_ready = 1'b0;
      a0 = acc_n;
      push_burst(32'h5000, 2, 32'hC0DE_0000);
      start_op(32'h5000, 8'd4);
      repeat (4) begin
         tick;
         calc_start = 1'b0;
      end
      @(negedge clk);
      chk("t6_acc", acc_n - a0, 2);
      chk("t6_busy", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      chk_zero("t6_rst");
      res_q.delete();
      sb_q.delete();
      tick;
      tick;
      rst_n = 1'b1;
      tick;
      rsp_x = 1'b1;
      tick;
      rsp_x = 1'b0;
      @(negedge clk);
      chk("t6_stray_idle", busy, 0);
      w0 = nwr;
      push_burst(32'h3000, 2, 32'hBEEF_0000);
      start_op(32'h3000, 8'd2);
      tick;
      calc_start = 1'b0;
      tick;
      rsp_x = 1'b1;
      tick;
      rsp_x = 1'b0;
      mem_req_ready = 1'b1;
      wait_wb(lat);
      chk("t6_latency", lat, 3);
      chk("t6_writes", nwr - w0, 2);
      chk("t6_sb_empty", sb_q.size(), 0);
      chk("t6_err", mma_wb_err, 0);
      finish_wb("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
